button_debouncer: RTL and testbench

Input-side conditioner for the four Basys3 push-buttons that feed the arithmetic/display demos. It synchronises each raw button to the system clock and filters out contact bounce. It then presents a clean level and single-cycle press/release pulses, so downstream logic such as adders, counters and the seven-segment driver sees exactly one event per physical press. Each button has an independent four-state filter FSM with a stability counter.

---
 rtl/button_debouncer.sv | 122 ++++++++++++
 tb/tb_button_debouncer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises four raw push-buttons and filters contact bounce into clean levels plus one-cycle press/release pulses.
// Define BTN_DEBOUNCE_RELEASE_PULSE_EN to build the release-pulse registers; otherwise btn_release is tied to 4'b0000.
module button_debouncer #(
   parameter int STABLE_CYCLES = 1000000,
   parameter int SYNC_STAGES   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn0,
   input  logic       btn1,
   input  logic       btn2,
   input  logic       btn3,
   output logic [3:0] btn_level,
   output logic [3:0] btn_press,
   output logic [3:0] btn_release
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      LOW_STABLE,
      RISE_CHECK,
      HIGH_STABLE,
      FALL_CHECK
   } state_t;

   logic [3:0] raw;
   assign raw = {btn3, btn2, btn1, btn0};

   for (genvar i = 0; i < 4; i++) begin : g_btn
      logic [SYNC_STAGES-1:0] sync;
      logic [CW-1:0]          cnt;
      state_t                 state;
      logic                   level_q;
      logic                   press_q;
      logic                   synced;
      logic                   done;

      assign synced = sync[SYNC_STAGES-1];
      // The counter already holds the sample taken on entry, so the next agreeing sample completes qualification.
      assign done   = (cnt >= LAST);

`ifdef BTN_DEBOUNCE_RELEASE_PULSE_EN
      logic release_q;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync    <= '0;
            state   <= LOW_STABLE;
            cnt     <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
`ifdef BTN_DEBOUNCE_RELEASE_PULSE_EN
            release_q <= 1'b0;
`endif
         end else begin
            sync    <= {sync[SYNC_STAGES-2:0], raw[i]};
            press_q <= 1'b0;
`ifdef BTN_DEBOUNCE_RELEASE_PULSE_EN
            release_q <= 1'b0;
`endif
            case (state)
               LOW_STABLE: begin
                  if (synced) begin
                     state <= RISE_CHECK;
                     cnt   <= CW'(1);
                  end
               end
               RISE_CHECK: begin
                  if (!synced) begin
                     state <= LOW_STABLE;
                     cnt   <= '0;
                  end else if (done) begin
                     state   <= HIGH_STABLE;
                     cnt     <= '0;
                     level_q <= 1'b1;
                     press_q <= 1'b1;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               HIGH_STABLE: begin
                  if (!synced) begin
                     state <= FALL_CHECK;
                     cnt   <= CW'(1);
                  end
               end
               FALL_CHECK: begin
                  if (synced) begin
                     state <= HIGH_STABLE;
                     cnt   <= '0;
                  end else if (done) begin
                     state   <= LOW_STABLE;
                     cnt     <= '0;
                     level_q <= 1'b0;
`ifdef BTN_DEBOUNCE_RELEASE_PULSE_EN
                     release_q <= 1'b1;
`endif
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               default: begin
                  state <= LOW_STABLE;
                  cnt   <= '0;
               end
            endcase
         end
      end

      assign btn_level[i] = level_q;
      assign btn_press[i] = press_q;
`ifdef BTN_DEBOUNCE_RELEASE_PULSE_EN
      assign btn_release[i] = release_q;
`else
      assign btn_release[i] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed scenarios for button_debouncer with STABLE_CYCLES=4, SYNC_STAGES=2.
// Expected outputs are queued per clock cycle as stimulus is applied and compared on the falling edge.
module tb_button_debouncer;

   logic       clk;
   logic       rst_n;
   logic       btn0;
   logic       btn1;
   logic       btn2;
   logic       btn3;
   logic [3:0] btn_level;
   logic [3:0] btn_press;
   logic [3:0] btn_release;

   int tests;
   int failures;
   int cyc;

   typedef struct {
      int         cyc;
      logic [3:0] lvl;
      logic [3:0] prs;
      logic [3:0] rel;
      string      tag;
   } exp_t;

   exp_t sb[$];

   button_debouncer #(
      .STABLE_CYCLES(4),
      .SYNC_STAGES(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn0(btn0),
      .btn1(btn1),
      .btn2(btn2),
      .btn3(btn3),
      .btn_level(btn_level),
      .btn_press(btn_press),
      .btn_release(btn_release)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   // Release pulses only exist when the optional feature is built.
   function automatic logic [3:0] rel_exp(input logic [3:0] v);
`ifdef BTN_DEBOUNCE_RELEASE_PULSE_EN
      return v;
`else
      return 4'b0000;
`endif
   endfunction

   task automatic push_expect(input int first, input int last, input logic [3:0] lvl,
                              input logic [3:0] prs, input logic [3:0] rel, input string tag);
      exp_t e;
      for (int k = first; k <= last; k++) begin
         e.cyc = cyc + k;
         e.lvl = lvl;
         e.prs = prs;
         e.rel = rel;
         e.tag = tag;
         sb.push_back(e);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic check_output(input string tag, input logic [3:0] lvl,
                               input logic [3:0] prs, input logic [3:0] rel);
      tests++;
      assert ({btn_level, btn_press, btn_release} === {lvl, prs, rel})
      else begin
         failures++;
         $error("[TB] FAIL %s: got level=%b press=%b release=%b, expected level=%b press=%b release=%b",
                tag, btn_level, btn_press, btn_release, lvl, prs, rel);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         tests++;
         assert (e.cyc == cyc && {btn_level, btn_press, btn_release} === {e.lvl, e.prs, e.rel})
         else begin
            failures++;
            $error("[TB] FAIL %s at cycle %0d (due %0d): got level=%b press=%b release=%b, expected level=%b press=%b release=%b",
                   e.tag, cyc, e.cyc, btn_level, btn_press, btn_release, e.lvl, e.prs, e.rel);
         end
      end
   end

   initial begin
      tests    = 0;
      failures = 0;
      rst_n    = 1'b0;
      btn0     = 1'b1;
      btn1     = 1'b0;
      btn2     = 1'b0;
      btn3     = 1'b0;
      wait_cycles(1);

      // Held reset with btn0 high, then a fresh press six edges after release.
      push_expect(1, 3, 4'b0000, 4'b0000, 4'b0000, "reset_hold");
      wait_cycles(3);
      rst_n = 1'b1;
      push_expect(1, 5, 4'b0000, 4'b0000, 4'b0000, "reset_btn0_wait");
      push_expect(6, 6, 4'b0001, 4'b0001, 4'b0000, "reset_btn0_press");
      push_expect(7, 9, 4'b0001, 4'b0000, 4'b0000, "reset_btn0_hold");
      wait_cycles(9);
      btn0 = 1'b0;
      push_expect(1, 5, 4'b0001, 4'b0000, 4'b0000, "btn0_fall_wait");
      push_expect(6, 6, 4'b0000, 4'b0000, rel_exp(4'b0001), "btn0_release");
      push_expect(7, 8, 4'b0000, 4'b0000, 4'b0000, "btn0_idle");
      wait_cycles(8);

      // Clean btn2 press held for 20 cycles.
      btn2 = 1'b1;
      push_expect(1, 5, 4'b0000, 4'b0000, 4'b0000, "btn2_rise_wait");
      push_expect(6, 6, 4'b0100, 4'b0100, 4'b0000, "btn2_press");
      push_expect(7, 25, 4'b0100, 4'b0000, 4'b0000, "btn2_hold");
      push_expect(26, 26, 4'b0000, 4'b0000, rel_exp(4'b0100), "btn2_release");
      push_expect(27, 28, 4'b0000, 4'b0000, 4'b0000, "btn2_idle");
      wait_cycles(20);
      btn2 = 1'b0;
      wait_cycles(8);

      // Bouncing btn1: 1,0,1,1,0 then a steady 1.
      btn1 = 1'b1;
      push_expect(1, 10, 4'b0000, 4'b0000, 4'b0000, "bounce_reject");
      push_expect(11, 11, 4'b0010, 4'b0010, 4'b0000, "bounce_press");
      push_expect(12, 14, 4'b0010, 4'b0000, 4'b0000, "bounce_hold");
      wait_cycles(1);
      btn1 = 1'b0;
      wait_cycles(1);
      btn1 = 1'b1;
      wait_cycles(2);
      btn1 = 1'b0;
      wait_cycles(1);
      btn1 = 1'b1;
      wait_cycles(9);
      btn1 = 1'b0;
      push_expect(1, 5, 4'b0010, 4'b0000, 4'b0000, "btn1_fall_wait");
      push_expect(6, 6, 4'b0000, 4'b0000, rel_exp(4'b0010), "btn1_release");
      push_expect(7, 8, 4'b0000, 4'b0000, 4'b0000, "btn1_idle");
      wait_cycles(8);

      // Three-cycle glitch on btn3 falls one sample short.
      btn3 = 1'b1;
      push_expect(1, 10, 4'b0000, 4'b0000, 4'b0000, "glitch_reject");
      wait_cycles(3);
      btn3 = 1'b0;
      wait_cycles(7);

      // Simultaneous btn0 and btn3.
      btn0 = 1'b1;
      btn3 = 1'b1;
      push_expect(1, 5, 4'b0000, 4'b0000, 4'b0000, "simul_wait");
      push_expect(6, 6, 4'b1001, 4'b1001, 4'b0000, "simul_press");
      push_expect(7, 8, 4'b1001, 4'b0000, 4'b0000, "simul_hold");
      wait_cycles(8);
      btn0 = 1'b0;
      btn3 = 1'b0;
      push_expect(1, 5, 4'b1001, 4'b0000, 4'b0000, "simul_fall_wait");
      push_expect(6, 6, 4'b0000, 4'b0000, rel_exp(4'b1001), "simul_release");
      push_expect(7, 8, 4'b0000, 4'b0000, 4'b0000, "simul_idle");
      wait_cycles(8);

      // Reset in the middle of btn1 qualification discards the partial count.
      btn1 = 1'b1;
      push_expect(1, 4, 4'b0000, 4'b0000, 4'b0000, "midq_wait");
      wait_cycles(4);
      rst_n = 1'b0;
      push_expect(1, 2, 4'b0000, 4'b0000, 4'b0000, "midq_reset");
      wait_cycles(2);
      rst_n = 1'b1;
      push_expect(1, 5, 4'b0000, 4'b0000, 4'b0000, "midq_requalify");
      push_expect(6, 6, 4'b0010, 4'b0010, 4'b0000, "midq_press");
      push_expect(7, 8, 4'b0010, 4'b0000, 4'b0000, "midq_hold");
      wait_cycles(8);
      btn1 = 1'b0;
      push_expect(1, 5, 4'b0010, 4'b0000, 4'b0000, "midq_fall_wait");
      push_expect(6, 6, 4'b0000, 4'b0000, rel_exp(4'b0010), "midq_release");
      push_expect(7, 8, 4'b0000, 4'b0000, 4'b0000, "midq_idle");
      wait_cycles(8);

      // Reset arriving while a press pulse is high clears it at once; the held button re-presses without a release.
      btn2 = 1'b1;
      push_expect(1, 5, 4'b0000, 4'b0000, 4'b0000, "pulse_rst_wait");
      push_expect(6, 6, 4'b0100, 4'b0100, 4'b0000, "pulse_rst_press");
      wait_cycles(6);
      rst_n = 1'b0;
      #1;
      check_output("pulse_rst_async_clear", 4'b0000, 4'b0000, 4'b0000);
      push_expect(1, 2, 4'b0000, 4'b0000, 4'b0000, "pulse_rst_hold");
      wait_cycles(2);
      rst_n = 1'b1;
      push_expect(1, 5, 4'b0000, 4'b0000, 4'b0000, "fresh_press_wait");
      push_expect(6, 6, 4'b0100, 4'b0100, 4'b0000, "fresh_press");
      push_expect(7, 9, 4'b0100, 4'b0000, 4'b0000, "fresh_hold");
      wait_cycles(9);
      btn2 = 1'b0;
      push_expect(1, 5, 4'b0100, 4'b0000, 4'b0000, "fresh_fall_wait");
      push_expect(6, 6, 4'b0000, 4'b0000, rel_exp(4'b0100), "fresh_release");
      push_expect(7, 8, 4'b0000, 4'b0000, 4'b0000, "fresh_idle");
      wait_cycles(8);

      // Drain any outstanding expectations within a bounded number of cycles.
      for (int k = 0; k < 20 && sb.size() > 0; k++) begin
         wait_cycles(1);
      end
      tests++;
      assert (sb.size() == 0)
      else begin
         failures++;
         $error("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
